mmio_timer: RTL and testbench

MMIO_TIMER -- requirements
Module: mmio_timer

---
 rtl/mmio_timer_pkg.sv | 22 ++
 rtl/mmio_timer_core.sv | 62 ++++++
 rtl/mmio_timer.sv | 79 +++++++
 tb/tb_mmio_timer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared constants for the MMIO timer: bus window, register offsets, TCON bits.
package mmio_timer_pkg;

  // addr[31:5] value selecting the 0x4000_0000..0x4000_001F window
  localparam logic [26:0] WinBase = 27'h2000000;

  // Word offsets decoded from addr[4:2]; 6 and 7 are reserved
  typedef enum logic [2:0] {
    OffTh      = 3'd0,
    OffTl      = 3'd1,
    OffTcon    = 3'd2,
    OffLed     = 3'd3,
    OffDigi    = 3'd4,
    OffSystick = 3'd5
  } reg_off_e;

  // TCON bit positions
  localparam int unsigned TconEn    = 0;
  localparam int unsigned TconIrqEn = 1;
  localparam int unsigned TconIrqSt = 2;

endpackage

// File: rtl/mmio_timer_core.sv
// Timer core: TH reload value, TL counter, TCON control/status and irq.
module timer_core
  import mmio_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        th_we,
  input  logic        tl_we,
  input  logic        tcon_we,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        reload;
  logic        set_status;

  // Next-state: software TL write beats the overflow reload; status set beats a clear
  always_comb begin
    reload     = tcon_q[TconEn] && (tl_q == 32'hFFFF_FFFF) && !tl_we;
    set_status = reload && tcon_q[TconIrqEn];

    th_d = th_we ? wdata : th_q;

    tl_d = tl_q;
    if (tl_we) begin
      tl_d = wdata;
    end else if (tcon_q[TconEn]) begin
      tl_d = reload ? th_q : tl_q + 32'd1;
    end

    tcon_d = tcon_q;
    if (tcon_we) begin
      tcon_d = wdata[2:0];
    end
    tcon_d[TconIrqSt] = tcon_d[TconIrqSt] | set_status;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th   = th_q;
  assign tl   = tl_q;
  assign tcon = tcon_q;
  assign irq  = tcon_q[TconIrqEn] & tcon_q[TconIrqSt];

endmodule

// File: rtl/mmio_timer.sv
// MMIO timer peripheral: bus decode, read mux, LED/DIGI registers and SYSTICK.
module mmio_timer
  import mmio_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic [31:0] systick
);

  logic [2:0]  off;
  logic        we;
  logic [31:0] th, tl;
  logic [2:0]  tcon;
  logic [7:0]  led_q;
  logic [11:0] digi_q;
  logic [31:0] systick_q;
  logic [31:0] rd_val;
  logic        unused_addr;

  assign unused_addr = ^addr[1:0];
  assign hit = (addr[31:5] == WinBase);
  assign off = addr[4:2];
  assign we  = hit & mem_write;

  timer_core u_core (
    .clk     (clk),
    .rst     (rst),
    .th_we   (we && (off == OffTh)),
    .tl_we   (we && (off == OffTl)),
    .tcon_we (we && (off == OffTcon)),
    .wdata   (wdata),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (irq)
  );

  // LED, DIGI and free-running SYSTICK; SYSTICK ignores bus writes
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
    end else begin
      if (we && (off == OffLed))  led_q  <= wdata[7:0];
      if (we && (off == OffDigi)) digi_q <= wdata[11:0];
      systick_q <= systick_q + 32'd1;
    end
  end

  // Read mux shows pre-write register values, so read+write returns the old value
  always_comb begin
    rd_val = '0;
    case (off)
      OffTh:      rd_val = th;
      OffTl:      rd_val = tl;
      OffTcon:    rd_val = {29'b0, tcon};
      OffLed:     rd_val = {24'b0, led_q};
      OffDigi:    rd_val = {20'b0, digi_q};
      OffSystick: rd_val = systick_q;
      default:    rd_val = '0;
    endcase
    rdata = (hit && mem_read) ? rd_val : 32'h0;
  end

  assign led     = led_q;
  assign digi    = digi_q;
  assign systick = systick_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer.
module tb_mmio_timer;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;
  logic [7:0]  led;
  logic [11:0] digi;
  logic [31:0] systick;

  int unsigned n_vec;
  int unsigned n_err;

  localparam logic [31:0] ATh      = 32'h4000_0000;
  localparam logic [31:0] ATl      = 32'h4000_0004;
  localparam logic [31:0] ATcon    = 32'h4000_0008;
  localparam logic [31:0] ALed     = 32'h4000_000C;
  localparam logic [31:0] ADigi    = 32'h4000_0010;
  localparam logic [31:0] ASystick = 32'h4000_0014;

  mmio_timer dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .rdata     (rdata),
    .hit       (hit),
    .irq       (irq),
    .led       (led),
    .digi      (digi),
    .systick   (systick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    wdata     = d;
    mem_write = 1'b1;
    tick(1);
    mem_write = 1'b0;
    addr      = '0;
    wdata     = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr     = a;
    mem_read = 1'b1;
    #1;
    d        = rdata;
    mem_read = 1'b0;
    addr     = '0;
    #1;
  endtask

  logic [31:0] v;
  logic [31:0] s0;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; addr = '0; wdata = '0; mem_read = 1'b0; mem_write = 1'b0;

    // Reset
    tick(2);
    rst = 1'b0;
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_led", {24'b0, led}, 32'h0);
    chk("rst_digi", {20'b0, digi}, 32'h0);
    chk("rst_systick", systick, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    tick(1);
    rd(ASystick, v);
    chk("systick_first", v, 32'h1);

    // Decode
    wr(ALed, 32'h0000_01A5);
    chk("led_write", {24'b0, led}, 32'hA5);
    rd(ALed, v);
    chk("led_read", v, 32'hA5);
    wr(32'h4000_0018, 32'hFFFF_FFFF);
    wr(32'h3FFF_FFFC, 32'h0000_0055);
    wr(32'h2000_000C, 32'h0000_0055);
    chk("miss_led", {24'b0, led}, 32'hA5);
    rd(32'h4000_0018, v);
    chk("rsvd_read", v, 32'h0);
    addr = ATh; #1;
    chk("noread_rdata", rdata, 32'h0);
    addr = 32'h4000_001F; #1;
    chk("hit_top", {31'b0, hit}, 32'h1);
    addr = 32'h4000_0020; #1;
    chk("hit_beyond", {31'b0, hit}, 32'h0);
    addr = '0;
    wr(ADigi, 32'hFFFF_ABCD);
    chk("digi_port", {20'b0, digi}, 32'hBCD);
    rd(ADigi, v);
    chk("digi_read", v, 32'hBCD);
    // Simultaneous read and write returns the old value
    addr = ALed; wdata = 32'h3C; mem_read = 1'b1; mem_write = 1'b1; #1;
    chk("rw_old", rdata, 32'hA5);
    tick(1);
    mem_read = 1'b0; mem_write = 1'b0;
    chk("rw_new", {24'b0, led}, 32'h3C);

    // Enable off holds TL
    wr(ATl, 32'h7);
    s0 = systick;
    tick(10);
    rd(ATl, v);
    chk("hold_tl", v, 32'h7);
    chk("hold_systick", systick, s0 + 32'd10);

    // Reload
    wr(ATh, 32'hFFFF_FFFC);
    wr(ATl, 32'hFFFF_FFFE);
    wr(ATcon, 32'h3);
    rd(ATl, v);  chk("rl_tl0", v, 32'hFFFF_FFFE);
    chk("rl_irq0", {31'b0, irq}, 32'h0);
    tick(1); rd(ATl, v); chk("rl_tl1", v, 32'hFFFF_FFFF);
    chk("rl_irq1", {31'b0, irq}, 32'h0);
    tick(1); rd(ATl, v); chk("rl_tl2", v, 32'hFFFF_FFFC);
    chk("rl_irq2", {31'b0, irq}, 32'h1);
    tick(1); rd(ATl, v); chk("rl_tl3", v, 32'hFFFF_FFFD);
    chk("rl_irq3", {31'b0, irq}, 32'h1);

    // Clear race
    wr(ATcon, 32'h3);
    chk("clr_irq", {31'b0, irq}, 32'h0);
    rd(ATl, v); chk("clr_tl", v, 32'hFFFF_FFFE);
    tick(1); rd(ATl, v); chk("clr_tl_ff", v, 32'hFFFF_FFFF);
    wr(ATcon, 32'h3);
    chk("race_irq", {31'b0, irq}, 32'h1);
    rd(ATcon, v); chk("race_tcon", v, 32'h7);
    rd(ATl, v); chk("race_tl", v, 32'hFFFF_FFFC);

    // TL write race
    wr(ATcon, 32'h3);
    tick(2);
    rd(ATl, v); chk("tlw_pre", v, 32'hFFFF_FFFF);
    wr(ATl, 32'h5);
    rd(ATl, v); chk("tlw_tl", v, 32'h5);
    rd(ATcon, v); chk("tlw_tcon", v, 32'h3);
    chk("tlw_irq", {31'b0, irq}, 32'h0);
    tick(1); rd(ATl, v); chk("tlw_next", v, 32'h6);

    // Reset mid-count beats a same-cycle write
    rst = 1'b1; addr = ALed; wdata = 32'hFF; mem_write = 1'b1;
    tick(1);
    rst = 1'b0; mem_write = 1'b0; addr = '0;
    chk("mrst_led", {24'b0, led}, 32'h0);
    chk("mrst_systick", systick, 32'h0);
    rd(ATl, v); chk("mrst_tl", v, 32'h0);
    rd(ATcon, v); chk("mrst_tcon", v, 32'h0);
    tick(2);
    rd(ATl, v); chk("mrst_tl_hold", v, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
